sixteen_bit_divider: RTL

Sequential unsigned divider that undoes what the adder datapath builds up: it divides a 16-bit dividend by a 16-bit divisor using restoring shift/subtract, one quotient bit per lane per cycle. The same `split` control as the adder datapath selects between one 16-bit operation and two independent 8-bit lanes. A start/busy/done handshake makes it a multi-cycle arithmetic unit beside the adders in the ALU datapath.

---
 rtl/sixteen_bit_divider_if.sv | 23 ++
 rtl/sixteen_bit_divider.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sixteen_bit_divider_if.sv
// Handshake and operand/result bundle for the sixteen_bit_divider.
// Bit 0 is the MSB throughout; lane 0 is bits [0:7], lane 1 is bits [8:15].
interface sixteen_bit_divider_if;
    logic        start;
    logic        split;
    logic [0:15] A;
    logic [0:15] B;
    logic [0:15] Q;
    logic [0:15] R;
    logic        busy;
    logic        done;
    logic [0:1]  divByZero;

    modport master (
        output start, split, A, B,
        input  Q, R, busy, done, divByZero
    );

    modport slave (
        input  start, split, A, B,
        output Q, R, busy, done, divByZero
    );
endinterface

// File: rtl/sixteen_bit_divider.sv
// Restoring shift/subtract divider: one 16-bit divide (split=1) or two
// independent 8-bit divides (split=0), one quotient bit per lane per cycle.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | iterating, counter counts down from N (16 or 8)
module sixteen_bit_divider (
    input logic                 clk,
    input logic                 rstN,
    sixteen_bit_divider_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        busy;
    logic        accept;
    logic        last;

    logic        mode16;
    logic [4:0]  cnt;
    logic [15:0] rem;
    logic [15:0] dvd;
    logic [15:0] dvs;
    logic [1:0]  dbz_pend;

    logic [15:0] rem_nxt;
    logic [15:0] dvd_nxt;

    logic [15:0] q_reg;
    logic [15:0] r_reg;
    logic [1:0]  dbz_reg;
    logic        done_reg;

    logic [15:0] a_in;
    logic [15:0] b_in;

    logic [16:0] full_tmp;
    logic        full_borrow;
    logic [8:0]  hi_tmp;
    logic        hi_borrow;
    logic [8:0]  lo_tmp;
    logic        lo_borrow;

    // Port vectors are [0:15] with bit 0 as MSB; internal vectors are [15:0].
    assign a_in = bus.A;
    assign b_in = bus.B;

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave RUN on the edge that performs the final iteration.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN:  if (cnt == 5'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy while running, accept in idle, last on final iteration.
    always_comb begin
        busy   = 1'b0;
        accept = 1'b0;
        last   = 1'b0;
        case (state)
            IDLE: accept = bus.start;
            RUN: begin
                busy = 1'b1;
                last = (cnt == 5'd1);
            end
            default: ;
        endcase
    end

    // One restoring step; the borrow test uses a compare one bit wider than
    // the lane so the shifted-out remainder bit is never lost.
    always_comb begin
        full_tmp    = {rem, dvd[15]};
        full_borrow = full_tmp < {1'b0, dvs};
        hi_tmp      = {rem[15:8], dvd[15]};
        hi_borrow   = hi_tmp < {1'b0, dvs[15:8]};
        lo_tmp      = {rem[7:0], dvd[7]};
        lo_borrow   = lo_tmp < {1'b0, dvs[7:0]};
        if (mode16) begin
            rem_nxt = full_borrow ? full_tmp[15:0] : (full_tmp[15:0] - dvs);
            dvd_nxt = {dvd[14:0], ~full_borrow};
        end else begin
            rem_nxt[15:8] = hi_borrow ? hi_tmp[7:0] : (hi_tmp[7:0] - dvs[15:8]);
            rem_nxt[7:0]  = lo_borrow ? lo_tmp[7:0] : (lo_tmp[7:0] - dvs[7:0]);
            dvd_nxt       = {dvd[14:8], ~hi_borrow, dvd[6:0], ~lo_borrow};
        end
    end

    // Working registers: load on accept, iterate while running.
    // A zero divisor needs no special path: every trial subtract succeeds,
    // giving an all-ones quotient and the dividend as remainder.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mode16   <= 1'b0;
            cnt      <= 5'd0;
            rem      <= 16'd0;
            dvd      <= 16'd0;
            dvs      <= 16'd0;
            dbz_pend <= 2'b00;
        end else if (accept) begin
            mode16   <= bus.split;
            cnt      <= bus.split ? 5'd16 : 5'd8;
            rem      <= 16'd0;
            dvd      <= a_in;
            dvs      <= b_in;
            dbz_pend <= bus.split ? {2{b_in == 16'd0}}
                                  : {b_in[15:8] == 8'd0, b_in[7:0] == 8'd0};
        end else if (busy) begin
            cnt <= cnt - 5'd1;
            rem <= rem_nxt;
            dvd <= dvd_nxt;
        end
    end

    // Result registers: updated only on the completing edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            q_reg    <= 16'd0;
            r_reg    <= 16'd0;
            dbz_reg  <= 2'b00;
            done_reg <= 1'b0;
        end else begin
            done_reg <= last;
            if (last) begin
                q_reg   <= dvd_nxt;
                r_reg   <= rem_nxt;
                dbz_reg <= dbz_pend;
            end
        end
    end

    assign bus.Q         = q_reg;
    assign bus.R         = r_reg;
    assign bus.divByZero = dbz_reg;
    assign bus.busy      = busy;
    assign bus.done      = done_reg;
endmodule
